// File: rtl/fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue
//
// Instruction buffer that sits between fetch and decode. It holds instruction/PC
// pairs in a first-word-fall-through FIFO and shows the head entry to decode.
// For the head entry it also provides:
//   - the raw immediate field Instr[31:7];
//   - a pre-decoded immediate-format select for the immediate extender.
//
// A synchronous Flush discards every entry on a branch/jump redirect.
//
// Ports
//   clk       in   1        rising-edge clock
//   rst_n     in   1        asynchronous active-low reset
//   InstrIn   in   32       fetched instruction word
//   PCIn      in   32       address of InstrIn
//   InValid   in   1        fetch offers InstrIn/PCIn
//   InReady   out  1        queue has room (registered state only)
//   Flush     in   1        discard all entries at the next edge
//   OutValid  out  1        head entry valid
//   OutReady  in   1        decode takes the head this cycle
//   Instr     out  32       head instruction (NOP when empty)
//   PC        out  32       head PC (0 when empty)
//   PCPlus4   out  32       PC + 4, wraps modulo 2^32
//   ImmIn     out  25       Instr[31:7]
//   ImmSrc    out  3        immediate format select for the head
//   Count     out  PTR_W+1  number of stored entries, 0..DEPTH
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high and Flush is low. InReady and OutValid depend only on registered state,
// so neither side sees a combinational path from the other. Fetch must hold
// InstrIn/PCIn stable while InValid && !InReady; the queue does not check this.
// -----------------------------------------------------------------------------
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      InstrIn,
  input  logic [31:0]      PCIn,
  input  logic             InValid,
  output logic             InReady,
  input  logic             Flush,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [31:0]      Instr,
  output logic [31:0]      PC,
  output logic [31:0]      PCPlus4,
  output logic [31:7]      ImmIn,
  output logic [2:0]       ImmSrc,
  output logic [PTR_W:0]   Count
);

  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W + 1)'(DEPTH);
  localparam logic [31:0]    NOP_INSTR = 32'h0000_0013; // addi x0,x0,0

  // Immediate format selects
  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_J    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  // ---------------------------------------------------------------------------
  // Storage (not reset: only the pointers and Count define what is valid)
  // ---------------------------------------------------------------------------
  logic [31:0] instr_mem_q [DEPTH];
  logic [31:0] pc_mem_q    [DEPTH];

  // ---------------------------------------------------------------------------
  // Pointer / count state
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic push;
  logic pop;
  logic in_ready;
  logic out_valid;

  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);

  // Flush blocks both transfers. Because InReady ignores OutReady, a full
  // queue refuses a push even in a cycle where it also pops.
  assign push = InValid && in_ready  && !Flush;
  assign pop  = OutValid && OutReady && !Flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the natural pointer overflow is the wrap.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= InstrIn;
      pc_mem_q[wr_ptr_q]    <= PCIn;
    end
  end

  // ---------------------------------------------------------------------------
  // Head presentation. Outputs come only from storage and the empty mask;
  // a pushed entry becomes visible after the edge that writes it.
  // ---------------------------------------------------------------------------
  logic [31:0] head_instr;
  logic [31:0] head_pc;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [2:0]  imm_src_o;

  assign head_instr = instr_mem_q[rd_ptr_q];
  assign head_pc    = pc_mem_q[rd_ptr_q];

  always_comb begin
    instr_o = NOP_INSTR;
    pc_o    = 32'h0;
    if (out_valid) begin
      instr_o = head_instr;
      pc_o    = head_pc;
    end
  end

  // The decode follows the masked word, so an empty queue reports the NOP's
  // I-format select.
  always_comb begin
    imm_src_o = IMM_NONE;
    case (instr_o[6:0])
      7'b0010011,
      7'b0000011,
      7'b1100111: imm_src_o = IMM_I;
      7'b0100011: imm_src_o = IMM_S;
      7'b1100011: imm_src_o = IMM_B;
      7'b1101111: imm_src_o = IMM_J;
      7'b0110111,
      7'b0010111: imm_src_o = IMM_U;
      default:    imm_src_o = IMM_NONE;
    endcase
  end

  assign InReady  = in_ready;
  assign OutValid = out_valid;
  assign Count    = count_q;
  assign Instr    = instr_o;
  assign PC       = pc_o;
  assign PCPlus4  = pc_o + 32'd4;
  assign ImmIn    = instr_o[31:7];
  assign ImmSrc   = imm_src_o;

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;

  logic        clk;
  logic        rst_n;
  logic [31:0] InstrIn;
  logic [31:0] PCIn;
  logic        InValid;
  logic        InReady;
  logic        Flush;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:7] ImmIn;
  logic [2:0]  ImmSrc;
  logic [2:0]  Count;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard of expected head indices for the streaming section
  logic [31:0] exp_q[$];

  fetch_decode_queue #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .InstrIn  (InstrIn),
    .PCIn     (PCIn),
    .InValid  (InValid),
    .InReady  (InReady),
    .Flush    (Flush),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Instr    (Instr),
    .PC       (PC),
    .PCPlus4  (PCPlus4),
    .ImmIn    (ImmIn),
    .ImmSrc   (ImmSrc),
    .Count    (Count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    InValid  = iv;
    InstrIn  = ins;
    PCIn     = pc;
    OutReady = ordy;
    Flush    = fl;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                          input logic [2:0] src, input logic [2:0] cnt);
    chk({tag, "_valid"}, 32'(OutValid), 32'd1);
    chk({tag, "_instr"}, Instr, ins);
    chk({tag, "_pc"}, PC, pc);
    chk({tag, "_immsrc"}, 32'(ImmSrc), 32'(src));
    chk({tag, "_count"}, 32'(Count), 32'(cnt));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 32'(OutValid), 32'd0);
    chk({tag, "_inready"}, 32'(InReady), 32'd1);
    chk({tag, "_count"}, 32'(Count), 32'd0);
    chk({tag, "_instr"}, Instr, 32'h0000_0013);
    chk({tag, "_pc"}, PC, 32'h0);
    chk({tag, "_pcp4"}, PCPlus4, 32'h4);
    chk({tag, "_immsrc"}, 32'(ImmSrc), 32'd0);
    chk({tag, "_immin"}, 32'(ImmIn), 32'h0);
  endtask

  function automatic logic [31:0] stream_instr(input int k);
    // addi x0,x0,k
    return {12'(k), 20'h00013};
  endfunction

  initial begin
    int next_k;
    int sz;
    logic do_push;
    logic do_pop;

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    chk_empty("reset");
    step();
    rst_n = 1'b1;
    step();
    chk_empty("idle");

    // Single push, no same-cycle bypass
    drive(1'b1, 32'h0050_0093, 32'h0000_0100, 1'b0, 1'b0);
    #1;
    chk("nobypass_valid", 32'(OutValid), 32'd0);
    chk("nobypass_instr", Instr, 32'h0000_0013);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk_head("addi", 32'h0050_0093, 32'h0000_0100, 3'b000, 3'd1);
    chk("addi_pcp4", PCPlus4, 32'h0000_0104);
    chk("addi_immin", 32'(ImmIn), 32'h0000_A001);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk_empty("addi_popped");

    // Fill to DEPTH with four formats
    drive(1'b1, 32'h0011_2023, 32'h0000_0200, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0000_0463, 32'h0000_0204, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0080_00EF, 32'h0000_0208, 1'b0, 1'b0); step();
    drive(1'b1, 32'h1234_50B7, 32'h0000_020C, 1'b0, 1'b0); step();
    chk("full_count", 32'(Count), 32'd4);
    chk("full_inready", 32'(InReady), 32'd0);
    // Push attempt while full is refused
    drive(1'b1, 32'hDEAD_BEEF, 32'h0000_0EEE, 1'b0, 1'b0); step();
    chk("full_hold_count", 32'(Count), 32'd4);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    chk_head("sw", 32'h0011_2023, 32'h0000_0200, 3'b001, 3'd4);
    chk("sw_immin", 32'(ImmIn), 32'h0000_2240);
    step();
    chk_head("beq", 32'h0000_0463, 32'h0000_0204, 3'b010, 3'd3);
    step();
    chk_head("jal", 32'h0080_00EF, 32'h0000_0208, 3'b011, 3'd2);
    step();
    chk_head("lui", 32'h1234_50B7, 32'h0000_020C, 3'b100, 3'd1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk_empty("drained");

    // Streaming: fill to 4, then push+pop every cycle, 10 entries total
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, stream_instr(k), 32'h1000 + 32'(4 * k), 1'b0, 1'b0);
      step();
      exp_q.push_back(32'(k));
    end
    chk("stream_full", 32'(Count), 32'd4);
    next_k = 4;
    while (next_k < 10) begin
      drive(1'b1, stream_instr(next_k), 32'h1000 + 32'(4 * next_k), 1'b1, 1'b0);
      #1;
      sz = exp_q.size();
      chk("stream_count", 32'(Count), 32'(sz));
      chk("stream_inready", 32'(InReady), (sz < 4) ? 32'd1 : 32'd0);
      chk("stream_instr", Instr, stream_instr(int'(exp_q[0])));
      chk("stream_pc", PC, 32'h1000 + 4 * exp_q[0]);
      do_push = (sz < 4);
      do_pop  = (sz > 0);
      step();
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(32'(next_k));
        next_k++;
      end
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("stream_end_count", 32'(Count), 32'd3);
    chk("stream_end_head", PC, 32'h1000 + 4 * 7);
    chk("stream_end_queue", 32'(exp_q.size()), 32'd3);

    // Flush with simultaneous push and pop
    drive(1'b1, 32'h00A0_0093, 32'hDEAD_0000, 1'b1, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk_empty("flush");
    step();
    chk_empty("flush_after");
    exp_q.delete();

    // R-type select and PC wrap
    drive(1'b1, 32'h0020_81B3, 32'h0000_0300, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0000_0013, 32'hFFFF_FFFC, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    chk_head("rtype", 32'h0020_81B3, 32'h0000_0300, 3'b111, 3'd2);
    step();
    drive(1'b1, 32'h0000_0013, 32'h0000_0400, 1'b0, 1'b0);
    #1;
    chk_head("wrap", 32'h0000_0013, 32'hFFFF_FFFC, 3'b000, 3'd1);
    chk("wrap_pcp4", PCPlus4, 32'h0000_0000);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(Count), 32'd2);

    // Asynchronous reset mid-stream, checked before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk_empty("async_rst");
    step();
    rst_n = 1'b1;
    step();
    chk_empty("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_queue.md
Name: fetch_decode_queue

Overview:
- Instruction buffer between instruction memory/fetch and the decode stage.
- Holds fetched instruction/PC pairs in a first-word-fall-through FIFO and presents the head entry to decode.
- For the head entry it also presents:
  - the raw immediate field ImmIn[31:7], which feeds the immediate extender;
  - a pre-decoded 3-bit ImmSrc select for that extender.
- Decouples fetch from decode stalls and supports a synchronous flush on branch/jump redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, must not be overridden.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- InstrIn  input  32  fetched instruction word
- PCIn  input  32  address of InstrIn
- InValid  input  1  fetch presents a valid InstrIn/PCIn
- InReady  output  1  queue can accept an entry this cycle
- Flush  input  1  discard all entries (redirect)
- OutValid  output  1  head entry valid
- OutReady  input  1  decode consumes head this cycle
- Instr  output  32  head instruction
- PC  output  32  head PC
- PCPlus4  output  32  PC + 4, modulo 2^32
- ImmIn  output  25  Instr[31:7], bits indexed [31:7]
- ImmSrc  output  3  immediate format select for head
- Count  output  PTR_W+1  number of stored entries, 0..DEPTH

Behaviour:
- Reset (rst_n low, asynchronous):
  - read/write pointers and Count = 0, OutValid = 0, InReady = 1.
  - Storage contents are not reset.
- Push: occurs when InValid && InReady && !Flush. The entry is written at the write pointer; the pointer increments and wraps DEPTH-1 -> 0.
- Pop: occurs when OutValid && OutReady && !Flush. The read pointer increments with the same wrap.
- InReady = (Count < DEPTH).
  - Registered-state function only; it does not depend on OutReady.
  - A full queue therefore refuses a push even in a cycle where it pops.
- OutValid = (Count != 0).
- Latency: an entry pushed at edge N is visible on Instr/PC with OutValid = 1 after edge N. There is no same-cycle bypass.
- Simultaneous push and pop: Count unchanged, both pointers advance.
- Count update: +1 on push-only, -1 on pop-only, 0 otherwise.
- Flush:
  - Synchronous, with highest priority.
  - At the next edge, pointers and Count = 0.
  - A same-cycle push and pop are both discarded.
  - InReady is 1 in the cycle after a flush.
- Empty-output masking: when OutValid = 0,
  - Instr = 32'h0000_0013 (addi x0,x0,0);
  - PC = 0 and PCPlus4 = 4;
  - ImmIn and ImmSrc derive from the masked Instr, so ImmSrc = 000.
- ImmIn is always Instr[31:7]. Decode of ImmSrc from Instr[6:0]:
  - 0010011, 0000011, 1100111 -> 000 (I)
  - 0100011 -> 001 (S)
  - 1100011 -> 010 (B)
  - 1101111 -> 011 (J)
  - 0110111, 0010111 -> 100 (U)
  - all other opcodes (including R-type 0110011) -> 111, for which the extender yields zero.
- Output timing: Instr/PC/PCPlus4/ImmIn/ImmSrc are combinational from the head storage entry and the masking logic only. There is no path from InstrIn to the outputs in the same cycle.
- Reset asserted mid-stream: all entries are lost immediately and outputs take their masked values while rst_n is low.
- Protocol rule: fetch must hold InstrIn/PCIn stable while InValid && !InReady. The queue does not check this.

Test Plan:
- Reset, then idle -> OutValid = 0, InReady = 1, Count = 0, Instr = 0x00000013, PC = 0, ImmSrc = 000.
- Push PC = 0x100, Instr = 0x00500093 (addi) with OutReady = 0 -> next cycle OutValid = 1, PC = 0x100, PCPlus4 = 0x104, ImmIn = Instr[31:7], ImmSrc = 000, Count = 1.
- Push 4 entries with OutReady = 0 (sw 0x00112023, beq 0x00000463, jal 0x008000EF, lui 0x123450B7) -> Count = 4, InReady = 0. Then pop one per cycle -> ImmSrc sequence 001, 010, 011, 100, in order, with matching PCs.
- Fill to 4, then hold InValid = 1 and OutReady = 1 -> first cycle pops only (Count = 3). After that, push and pop together each cycle and Count stays 3. Pointers wrap past DEPTH-1 with no loss or reordering across 10 entries.
- Count = 3, assert Flush together with InValid and OutReady -> next cycle Count = 0, OutValid = 0, InReady = 1. The pushed entry never appears on the output.
- Push R-type 0x002081B3 -> ImmSrc = 111. Push PCIn = 0xFFFFFFFC -> PCPlus4 = 0x00000000. Assert rst_n low mid-stream with Count = 2 -> Count = 0 and OutValid = 0 without waiting for a clock edge.
